// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVERFLOW_EN to add a registered two's-complement overflow output.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_sum_c;
    logic             fa_carry_c;
    logic             last_c;

    // Single full-adder slice over the operand LSBs and the running carry
    assign fa_sum_c   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_c     = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = augend;
                    b_d     = addend;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {fa_sum_c, sum_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_carry_c;
                if (last_c) begin
                    cout_d  = fa_carry_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake flags are pure decodes of the state register
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is the running carry on the last slice
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && last_c) begin
            ovf_d = carry_q ^ fa_carry_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): results queued at drive time, compared on out_valid.
module tb_serial_adder;

    localparam int unsigned W = 8;
    localparam int LIMIT = 50;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] augend = '0;
    logic [W-1:0] addend = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .augend    (augend),
        .addend    (addend),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t         e;
        logic [W:0]   full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Drive operands, wait (bounded) for acceptance, then drop in_valid
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int n = 0;
        augend   = a;
        addend   = b;
        carry_in = ci;
        in_valid = 1'b1;
        sb.push_back(model(a, b, ci));
        while (in_ready !== 1'b1 && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_accept in_ready=%b expected=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted from the acceptance edge until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   lat;
        #2;
        checks++;
        if (sum !== '0 || carry_out !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs sum=%h cout=%b ov=%b expected 00/0/0", sum, carry_out, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b expected=1", in_ready);
        end
        send(8'h00, 8'h00, 1'b0);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (lat != int'(W)) begin
            failures++;
            $display("FAIL zero_latency got=%0d expected=%0d", lat, W);
        end
        checks++;
        if (sum !== e.s || carry_out !== e.c) begin
            failures++;
            $display("FAIL zero_result got=%h/%b expected=%h/%b", sum, carry_out, e.s, e.c);
        end
    endtask

    task automatic test_add();
        logic [W-1:0] ta [3] = '{8'hFF, 8'h5A, 8'h3C};
        logic [W-1:0] tb [3] = '{8'h01, 8'hA5, 8'h42};
        logic         tc [3] = '{1'b0, 1'b1, 1'b0};
        exp_t e;
        int   lat;
        for (int i = 0; i < 3; i++) begin
            send(ta[i], tb[i], tc[i]);
            wait_valid(lat);
            e = sb.pop_front();
            checks++;
            if (lat != int'(W)) begin
                failures++;
                $display("FAIL add_latency[%0d] got=%0d expected=%0d", i, lat, W);
            end
            checks++;
            if (sum !== e.s || carry_out !== e.c) begin
                failures++;
                $display("FAIL add_result[%0d] got=%h/%b expected=%h/%b", i, sum, carry_out, e.s, e.c);
            end
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL add_return_idle[%0d] in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        int   bad = 0;
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0);
        wait_valid(lat);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || sum !== e.s || carry_out !== e.c) bad++;
        end
        checks++;
        if (bad != 0 || e.s !== 8'h46) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d sum=%h expected 0 cycles, sum=%h", bad, sum, e.s);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (sum !== e.s) begin
            failures++;
            $display("FAIL bp_sum_kept got=%h expected=%h", sum, e.s);
        end
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        int   lat = 0;
        int   busy_ready = 0;
        send(8'h01, 8'h01, 1'b0);
        augend   = 8'hAA;
        addend   = 8'h55;
        carry_in = 1'b0;
        in_valid = 1'b1;
        sb.push_back(model(8'hAA, 8'h55, 1'b0));
        while (out_valid !== 1'b1 && lat < LIMIT) begin
            if (in_ready !== 1'b0) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (busy_ready != 0 || lat != int'(W)) begin
            failures++;
            $display("FAIL busy_in_ready ready_cycles=%0d lat=%0d expected 0/%0d", busy_ready, lat, W);
        end
        checks++;
        if (sum !== e.s || carry_out !== e.c) begin
            failures++;
            $display("FAIL busy_result got=%h/%b expected=%h/%b", sum, carry_out, e.s, e.c);
        end
        lat = 0;
        while (in_ready !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (sum !== e.s || carry_out !== e.c || lat != int'(W)) begin
            failures++;
            $display("FAIL busy_second got=%h/%b lat=%0d expected=%h/%b lat=%0d", sum, carry_out, lat, e.s, e.c, W);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   lat;
        @(posedge clk); #1;
        send(8'h33, 8'h11, 1'b0);
        void'(sb.pop_back());
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sum !== '0 || carry_out !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset sum=%h cout=%b ov=%b expected 00/0/0", sum, carry_out, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h80, 8'h80, 1'b0);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (sum !== e.s || carry_out !== e.c || lat != int'(W)) begin
            failures++;
            $display("FAIL post_reset_op got=%h/%b lat=%0d expected=%h/%b lat=%0d", sum, carry_out, lat, e.s, e.c, W);
        end
    endtask

`ifdef SERIAL_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [W-1:0] ta [2] = '{8'h7F, 8'hFF};
        exp_t e;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            send(ta[i], 8'h01, 1'b0);
            wait_valid(lat);
            e = sb.pop_front();
            checks++;
            if (sum !== e.s || carry_out !== e.c || overflow !== e.v) begin
                failures++;
                $display("FAIL overflow[%0d] got=%h/%b/%b expected=%h/%b/%b", i, sum, carry_out, overflow, e.s, e.c, e.v);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder; the additive counterpart of the team's subtractor cells.
- Processes one bit per clock, LSB first, using a single full-adder slice and a registered carry.
- Operands enter through a valid/ready input handshake; the result leaves through a valid/ready output handshake.
- Serves as the area-cheap arithmetic unit for datapaths where latency is not critical.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2 to 64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and carry_in valid
- in_ready  output  1  block can accept operands
- augend  input  WIDTH  first operand
- addend  input  WIDTH  second operand
- carry_in  input  1  initial carry
- out_valid  output  1  sum and carry_out valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  augend + addend + carry_in, modulo 2^WIDTH
- carry_out  output  1  final carry, bit WIDTH of the full result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, applied immediately, no clock required):
  - state returns to IDLE;
  - sum=0, carry_out=0, out_valid=0;
  - bit counter, operand shift registers and carry register all 0;
  - in_ready=1 from the first edge after rst_n deasserts.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only, with no combinational path from any input.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with in_valid && in_ready: load augend and addend into shift registers, carry register <= carry_in, counter <= 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Compute s = a0 ^ b0 ^ c and c' = majority(a0, b0, c), where a0 and b0 are the LSBs of the operand shift registers.
  - Shift s into the sum register at the MSB; the register shifts right.
  - Shift both operand registers right; carry <= c'; counter++.
  - On the edge where counter == WIDTH-1: carry_out <= c', go to DONE.
- Latency: out_valid rises exactly WIDTH clk edges after the acceptance edge (8 for the default). Throughput is one operation per WIDTH+2 cycles minimum.
- DONE:
  - sum and carry_out held stable.
  - On an edge with out_ready high: go to IDLE; sum and carry_out keep their values until the next operation overwrites them.
  - out_ready low: stay in DONE indefinitely (back-pressure); no data loss.
- Input changes during RUN or DONE (in_valid, augend, addend, carry_in) are ignored; in_ready is 0 there.
- out_ready is ignored outside DONE.
- Counter width: clog2(WIDTH). Terminal count is WIDTH-1; no wrap beyond it.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted, all outputs take their reset values, and no partial result is ever presented.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit): two's-complement signed overflow = carry into MSB XOR carry out of MSB.
  - overflow is registered on the last RUN edge alongside carry_out and is valid while out_valid is high.
  - Reset value 0; held through DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- Reset then 0x00+0x00, carry_in=0, out_ready=1 -> in_ready=1 after reset; out_valid high 8 edges after acceptance; sum=0x00, carry_out=0.
- 0xFF+0x01, carry_in=0 -> sum=0x00, carry_out=1. 0x5A+0xA5, carry_in=1 -> sum=0x00, carry_out=1. 0x3C+0x42, carry_in=0 -> sum=0x7E, carry_out=0.
- Back-pressure: 0x12+0x34 with out_ready held low for 5 cycles after out_valid -> sum=0x46 stable and out_valid=1 for all 5 cycles; raising out_ready -> IDLE and in_ready=1 on the next edge.
- New operands (0xAA+0x55) driven with in_valid=1 during RUN of 0x01+0x01 -> result still 0x02; in_ready=0 throughout RUN; the 0xAA+0x55 pair is accepted only once IDLE is re-entered.
- Reset pulse on rst_n at the 4th RUN cycle -> outputs go to 0 immediately, without a clock edge; next operation 0x80+0x80 -> sum=0x00, carry_out=1.
- With SERIAL_ADDER_OVERFLOW_EN: 0x7F+0x01 -> sum=0x80, carry_out=0, overflow=1; 0xFF+0x01 -> overflow=0.
